// File: rtl/ptw_mem_arbiter_if.sv
// Bundle of the walker-side and memory-side signals of the PTW memory arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the environment:
// the walkers, the flush source and the memory read port.
interface ptw_mem_arbiter_if #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*ADDR_W-1:0] req_addr;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ-1:0]        req_ack;
    logic [DATA_W-1:0]       resp_data;
    logic                    resp_err;
    logic [N_REQ-1:0]        grant;
    logic                    flush_req;
    logic                    flush_done;
    logic                    mem_req_valid;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic                    mem_req_ready;
    logic                    mem_resp_valid;
    logic [DATA_W-1:0]       mem_resp_data;
    logic                    mem_resp_err;

    modport master (
        input  req_valid, req_addr, req_lock, flush_req,
        input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        output req_ack, resp_data, resp_err, grant, flush_done,
        output mem_req_valid, mem_req_addr
    );

    modport slave (
        output req_valid, req_addr, req_lock, flush_req,
        output mem_req_ready, mem_resp_valid, mem_resp_data, mem_resp_err,
        input  req_ack, resp_data, resp_err, grant, flush_done,
        input  mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/ptw_mem_arbiter.sv
// Page-table-walk memory arbiter.
// Round-robin sharing of one PTE read port between the walker FSMs, with a per-walk lock so that
// a multi-level walk keeps the port. New grants are held off while an MMU flush is requested.
module ptw_mem_arbiter #(
    parameter int unsigned N_REQ  = 3,
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) (
    input logic               clk,
    input logic               rst,
    ptw_mem_arbiter_if.master bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic              lock_q, lock_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    // Set once flush_done has pulsed; re-armed when flush_req drops.
    logic              flush_seen_q, flush_seen_d;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  win_idx;
    logic              win_any;

    // Round-robin scan: first valid requester at or after rr_q, wrapping.
    always_comb begin
        pick_any = 1'b0;
        pick_idx = '0;
        scan_idx = '0;
        // Walk from the farthest offset down so the nearest valid requester is written last.
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            scan_idx = IDX_W'((int'(rr_q) + k) % int'(N_REQ));
            if (bus.req_valid[scan_idx]) begin
                pick_any = 1'b1;
                pick_idx = scan_idx;
            end
        end
    end

    // Next-state logic for the arbitration FSM and its datapath registers.
    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        owner_d        = owner_q;
        rr_d           = rr_q;
        lock_d         = lock_q;
        addr_d         = addr_q;
        data_d         = data_q;
        err_d          = err_q;
        flush_seen_d   = flush_seen_q & bus.flush_req;
        bus.flush_done = 1'b0;
        win_any        = 1'b0;
        win_idx        = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    // Flush accepted: drop any held walk lock, no new grant.
                    bus.flush_done = ~flush_seen_q;
                    flush_seen_d   = 1'b1;
                    lock_d         = 1'b0;
                    grant_d        = '0;
                end else begin
                    if (lock_q && bus.req_valid[owner_q]) begin
                        win_any = 1'b1;
                        win_idx = owner_q;
                    end else begin
                        // Either no lock or the locked walk was aborted.
                        lock_d  = 1'b0;
                        grant_d = '0;
                        win_any = pick_any;
                        win_idx = pick_idx;
                    end
                    if (win_any) begin
                        grant_d = ONE_HOT0 << win_idx;
                        owner_d = win_idx;
                        addr_d  = bus.req_addr[win_idx * ADDR_W +: ADDR_W];
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_resp_valid) begin
                    data_d  = bus.mem_resp_data;
                    err_d   = bus.mem_resp_err;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (bus.req_lock[owner_q]) begin
                    lock_d = 1'b1;
                end else begin
                    lock_d  = 1'b0;
                    grant_d = '0;
                    rr_d    = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset drops any in-flight transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            rr_q         <= '0;
            lock_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
            flush_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            lock_q       <= lock_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            err_q        <= err_d;
            flush_seen_q <= flush_seen_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        bus.mem_req_valid = (state_q == ST_ISSUE);
        bus.mem_req_addr  = addr_q;
        bus.req_ack       = (state_q == ST_RESP) ? grant_q : '0;
        bus.resp_data     = data_q;
        bus.resp_err      = err_q;
        bus.grant         = grant_q;
    end
endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Self-checking bench for ptw_mem_arbiter: a per-cycle vector table plus directed sequences
// for memory back-pressure, flush while busy and asynchronous reset.
module tb_ptw_mem_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   hs_cnt;

    localparam logic [63:0] A0 = 64'h0000_0000_8000_1000;
    localparam logic [63:0] A1 = 64'h0000_0000_8000_2008;
    localparam logic [63:0] A2 = 64'h0000_0000_8000_3010;

    ptw_mem_arbiter_if #(.N_REQ(3), .ADDR_W(64), .DATA_W(64)) bus ();

    ptw_mem_arbiter #(.N_REQ(3), .ADDR_W(64), .DATA_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  rv;
        logic [2:0]  lk;
        logic        rdy;
        logic        rspv;
        logic        rerr;
        logic [63:0] rdata;
        logic [2:0]  e_grant;
        logic [2:0]  e_ack;
        logic        e_mrv;
        logic [63:0] e_data;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic [2:0] rv, input logic [2:0] lk, input logic rdy,
                     input logic rspv, input logic rerr, input logic [63:0] rdata,
                     input logic [2:0] e_grant, input logic [2:0] e_ack, input logic e_mrv,
                     input logic [63:0] e_data, input logic e_err);
        vec_t r;
        r.rv = rv; r.lk = lk; r.rdy = rdy; r.rspv = rspv; r.rerr = rerr; r.rdata = rdata;
        r.e_grant = e_grant; r.e_ack = e_ack; r.e_mrv = e_mrv; r.e_data = e_data;
        r.e_err = e_err;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] addr_of(input logic [2:0] g);
        case (g)
            3'b001:  return A0;
            3'b010:  return A1;
            3'b100:  return A2;
            default: return 64'h0;
        endcase
    endfunction

    // Drive one cycle's inputs at the falling edge, let combinational outputs settle.
    task automatic drive(input logic [2:0] rv, input logic [2:0] lk, input logic fl,
                         input logic rdy, input logic rspv, input logic rerr,
                         input logic [63:0] rdata);
        @(negedge clk);
        bus.req_valid      = rv;
        bus.req_lock       = lk;
        bus.flush_req      = fl;
        bus.mem_req_ready  = rdy;
        bus.mem_resp_valid = rspv;
        bus.mem_resp_err   = rerr;
        bus.mem_resp_data  = rdata;
        #1;
        if (bus.mem_req_valid && bus.mem_req_ready) hs_cnt++;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs_cnt = 0;
        rst = 1'b1;
        bus.req_valid      = '0;
        bus.req_addr       = {A2, A1, A0};
        bus.req_lock       = '0;
        bus.flush_req      = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        bus.mem_resp_err   = 1'b0;

        // Round robin (110 from reset, then 111), lock walk 1,1,0 on req 2, error response.
        v(3'b110, 3'b000, 1, 0, 0, 64'h0,    3'b000, 3'b000, 0, 64'h0, 0);
        v(3'b110, 3'b000, 1, 0, 0, 64'h0,    3'b010, 3'b000, 1, 64'h0, 0);
        v(3'b110, 3'b000, 1, 0, 0, 64'h0,    3'b010, 3'b000, 0, 64'h0, 0);
        v(3'b110, 3'b000, 1, 1, 0, 64'h1111, 3'b010, 3'b000, 0, 64'h0, 0);
        v(3'b110, 3'b000, 1, 0, 0, 64'h0,    3'b010, 3'b010, 0, 64'h1111, 0);
        v(3'b100, 3'b000, 1, 0, 0, 64'h0,    3'b000, 3'b000, 0, 64'h0, 0);
        v(3'b100, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b000, 1, 64'h0, 0);
        v(3'b100, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b000, 0, 64'h0, 0);
        v(3'b100, 3'b000, 1, 1, 0, 64'h2222, 3'b100, 3'b000, 0, 64'h0, 0);
        v(3'b100, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b100, 0, 64'h2222, 0);
        v(3'b111, 3'b000, 1, 0, 0, 64'h0,    3'b000, 3'b000, 0, 64'h0, 0);
        v(3'b001, 3'b000, 1, 0, 0, 64'h0,    3'b001, 3'b000, 1, 64'h0, 0);
        v(3'b001, 3'b000, 1, 1, 0, 64'h3333, 3'b001, 3'b000, 0, 64'h0, 0);
        v(3'b001, 3'b000, 1, 0, 0, 64'h0,    3'b001, 3'b001, 0, 64'h3333, 0);
        v(3'b000, 3'b000, 1, 0, 0, 64'h0,    3'b000, 3'b000, 0, 64'h0, 0);
        v(3'b101, 3'b000, 1, 0, 0, 64'h0,    3'b000, 3'b000, 0, 64'h0, 0);
        v(3'b101, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b000, 1, 64'h0, 0);
        v(3'b101, 3'b000, 1, 1, 0, 64'h4444, 3'b100, 3'b000, 0, 64'h0, 0);
        v(3'b101, 3'b100, 1, 0, 0, 64'h0,    3'b100, 3'b100, 0, 64'h4444, 0);
        v(3'b101, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b000, 0, 64'h0, 0);
        v(3'b101, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b000, 1, 64'h0, 0);
        v(3'b101, 3'b000, 1, 1, 0, 64'h5555, 3'b100, 3'b000, 0, 64'h0, 0);
        v(3'b101, 3'b100, 1, 0, 0, 64'h0,    3'b100, 3'b100, 0, 64'h5555, 0);
        v(3'b101, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b000, 0, 64'h0, 0);
        v(3'b101, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b000, 1, 64'h0, 0);
        v(3'b101, 3'b000, 1, 1, 0, 64'h6666, 3'b100, 3'b000, 0, 64'h0, 0);
        v(3'b101, 3'b000, 1, 0, 0, 64'h0,    3'b100, 3'b100, 0, 64'h6666, 0);
        v(3'b001, 3'b000, 1, 0, 0, 64'h0,    3'b000, 3'b000, 0, 64'h0, 0);
        v(3'b001, 3'b000, 1, 0, 0, 64'h0,    3'b001, 3'b000, 1, 64'h0, 0);
        v(3'b001, 3'b000, 1, 1, 1, 64'hDEAD, 3'b001, 3'b000, 0, 64'h0, 0);
        v(3'b001, 3'b000, 1, 0, 0, 64'h0,    3'b001, 3'b001, 0, 64'hDEAD, 1);
        v(3'b000, 3'b000, 1, 0, 0, 64'h0,    3'b000, 3'b000, 0, 64'h0, 0);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset grant", 64'(bus.grant), 64'h0);
        chk("reset req_ack", 64'(bus.req_ack), 64'h0);
        chk("reset mem_req_valid", 64'(bus.mem_req_valid), 64'h0);
        chk("reset mem_req_addr", bus.mem_req_addr, 64'h0);
        chk("reset resp_data", bus.resp_data, 64'h0);
        chk("reset flush_done", 64'(bus.flush_done), 64'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rv, vecs[i].lk, 1'b0, vecs[i].rdy, vecs[i].rspv, vecs[i].rerr,
                  vecs[i].rdata);
            chk($sformatf("v%0d grant", i), 64'(bus.grant), 64'(vecs[i].e_grant));
            chk($sformatf("v%0d req_ack", i), 64'(bus.req_ack), 64'(vecs[i].e_ack));
            chk($sformatf("v%0d mem_req_valid", i), 64'(bus.mem_req_valid),
                64'(vecs[i].e_mrv));
            chk($sformatf("v%0d flush_done", i), 64'(bus.flush_done), 64'h0);
            if (vecs[i].e_mrv) begin
                chk($sformatf("v%0d mem_req_addr", i), bus.mem_req_addr,
                    addr_of(vecs[i].e_grant));
            end
            if (vecs[i].e_ack != 3'b000) begin
                chk($sformatf("v%0d resp_data", i), bus.resp_data, vecs[i].e_data);
                chk($sformatf("v%0d resp_err", i), 64'(bus.resp_err), 64'(vecs[i].e_err));
            end
        end

        // Back-pressure: ready low for 5 cycles, request held stable, one handshake only.
        hs_cnt = 0;
        drive(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            drive(3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
            chk($sformatf("bp%0d mem_req_valid", i), 64'(bus.mem_req_valid), 64'h1);
            chk($sformatf("bp%0d mem_req_addr", i), bus.mem_req_addr, A1);
        end
        drive(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("bp accept mem_req_valid", 64'(bus.mem_req_valid), 64'h1);
        drive(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("bp wait mem_req_valid", 64'(bus.mem_req_valid), 64'h0);
        drive(3'b010, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 64'hABCD);
        drive(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("bp req_ack", 64'(bus.req_ack), 64'h2);
        chk("bp resp_data", bus.resp_data, 64'hABCD);
        chk("bp handshakes", 64'(hs_cnt), 64'h1);

        // Flush raised during WAIT: ack first, then one flush_done, then no grant.
        drive(3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        drive(3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("fl issue grant", 64'(bus.grant), 64'h1);
        drive(3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("fl wait flush_done", 64'(bus.flush_done), 64'h0);
        drive(3'b001, 3'b000, 1'b1, 1'b1, 1'b1, 1'b0, 64'h77);
        drive(3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("fl resp req_ack", 64'(bus.req_ack), 64'h1);
        chk("fl resp flush_done", 64'(bus.flush_done), 64'h0);
        drive(3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("fl idle flush_done", 64'(bus.flush_done), 64'h1);
        chk("fl idle grant", 64'(bus.grant), 64'h0);
        for (int i = 0; i < 2; i++) begin
            drive(3'b001, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
            chk($sformatf("fl hold%0d flush_done", i), 64'(bus.flush_done), 64'h0);
            chk($sformatf("fl hold%0d grant", i), 64'(bus.grant), 64'h0);
            chk($sformatf("fl hold%0d mem_req_valid", i), 64'(bus.mem_req_valid), 64'h0);
        end
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("fl release grant", 64'(bus.grant), 64'h0);

        // Asynchronous reset in WAIT, then a stray response.
        drive(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        drive(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("rst issue mem_req_valid", 64'(bus.mem_req_valid), 64'h1);
        drive(3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("rst wait grant", 64'(bus.grant), 64'h2);
        chk("rst wait resp_data", bus.resp_data, 64'h77);
        #1;
        rst = 1'b1;
        #1;
        chk("rst async grant", 64'(bus.grant), 64'h0);
        chk("rst async mem_req_addr", bus.mem_req_addr, 64'h0);
        chk("rst async resp_data", bus.resp_data, 64'h0);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        rst = 1'b0;
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 64'h99);
        drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
        chk("rst stray req_ack", 64'(bus.req_ack), 64'h0);
        chk("rst stray resp_data", bus.resp_data, 64'h0);
        chk("rst stray grant", 64'(bus.grant), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
